sdram_req_queue: RTL and testbench

- Upstream front-end of the SDRAM controller. Buffers host read/write requests in an in-order queue and drives the controller's inport request interface.
- Limits outstanding requests and filters out-of-range addresses by returning an error response locally, without issuing to SDRAM.
- Returns controller responses to the host in issue order, each registered one cycle.

---
 rtl/sdram_req_queue_pkg.sv | 18 +
 rtl/sdram_req_fifo.sv | 60 ++++++
 rtl/sdram_req_queue.sv | 118 +++++++++++
 tb/tb_sdram_req_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_req_queue_pkg.sv
// Shared definitions for the SDRAM request front-end: address range and request record.
package sdram_req_queue_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;

  typedef struct packed {
    logic [3:0]  wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } sdram_req_t;

  // Bits above SDRAM_ADDR_W must be clear for the address to reach the device.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >> (SDRAM_ADDR_W + 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Registered synchronous FIFO of SDRAM requests; head is read straight from storage.
module sdram_req_fifo
  import sdram_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  sdram_req_t             push_data_i,
  input  logic                   pop_i,
  output sdram_req_t             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  sdram_req_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == FULL_LVL);
  assign empty_o = (count == '0);
  assign level_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Host-side request queue for the SDRAM controller: ordered issue, outstanding limit,
// local error responses for out-of-range addresses, registered response return.
module sdram_req_queue
  import sdram_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             host_wr_i,
  input  logic                   host_rd_i,
  input  logic [31:0]            host_addr_i,
  input  logic [31:0]            host_write_data_i,
  output logic                   host_accept_o,
  output logic                   host_ack_o,
  output logic                   host_error_o,
  output logic [31:0]            host_read_data_o,
  output logic [3:0]             inport_wr_o,
  output logic                   inport_rd_o,
  output logic [31:0]            inport_addr_o,
  output logic [31:0]            inport_write_data_o,
  input  logic                   inport_accept_i,
  input  logic                   inport_ack_i,
  input  logic                   inport_error_i,
  input  logic [31:0]            inport_read_data_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   protocol_err_o
);

  sdram_req_t push_req;
  sdram_req_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       head_in_range;
  logic       issue;
  logic       pop_issue;
  logic       pop_local;
  logic [2:0] outstanding;
  logic       out_zero;
  logic       out_room;
  logic       ack_counted;

  assign host_accept_o = ~full;
  assign push          = (host_rd_i | (|host_wr_i)) & ~full;

  // A combined read+write request is stored as a plain write.
  always_comb begin
    push_req      = '0;
    push_req.wr   = host_wr_i;
    push_req.rd   = host_rd_i & ~(|host_wr_i);
    push_req.addr = host_addr_i;
    push_req.data = host_write_data_i;
  end

  sdram_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_req),
    .pop_i      (pop_issue | pop_local),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level_o)
  );

  assign out_zero      = (outstanding == 3'd0);
  assign out_room      = (outstanding < 3'(MAX_OUTSTANDING));
  assign head_in_range = addr_in_range(head.addr);

  assign issue               = ~empty & head_in_range & out_room;
  assign inport_rd_o         = issue & head.rd;
  assign inport_wr_o         = issue ? head.wr : '0;
  assign inport_addr_o       = head.addr;
  assign inport_write_data_o = head.data;

  assign pop_issue = issue & inport_accept_i;
  // Out-of-range heads retire only once the controller is drained so responses stay in order.
  assign pop_local   = ~empty & ~head_in_range & out_zero;
  assign ack_counted = inport_ack_i & ~out_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding    <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (inport_ack_i && out_zero) begin
        protocol_err_o <= 1'b1;
      end
      case ({pop_issue, ack_counted})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_ack_o       <= 1'b0;
      host_error_o     <= 1'b0;
      host_read_data_o <= '0;
    end else begin
      host_ack_o   <= inport_ack_i | pop_local;
      host_error_o <= pop_local | (inport_ack_i & inport_error_i);
      if (pop_local) begin
        host_read_data_o <= '0;
      end else if (inport_ack_i) begin
        host_read_data_o <= inport_read_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Self-checking bench for sdram_req_queue: vector table, directed corner sequences, random vs. queue model.
module tb_sdram_req_queue;
  import sdram_req_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  host_wr_i;
  logic        host_rd_i;
  logic [31:0] host_addr_i;
  logic [31:0] host_write_data_i;
  logic        host_accept_o;
  logic        host_ack_o;
  logic        host_error_o;
  logic [31:0] host_read_data_o;
  logic [3:0]  inport_wr_o;
  logic        inport_rd_o;
  logic [31:0] inport_addr_o;
  logic [31:0] inport_write_data_o;
  logic        inport_accept_i;
  logic        inport_ack_i;
  logic        inport_error_i;
  logic [31:0] inport_read_data_i;
  logic [2:0]  level_o;
  logic        protocol_err_o;

  always #5 clk = ~clk;

  sdram_req_queue #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .host_wr_i          (host_wr_i),
    .host_rd_i          (host_rd_i),
    .host_addr_i        (host_addr_i),
    .host_write_data_i  (host_write_data_i),
    .host_accept_o      (host_accept_o),
    .host_ack_o         (host_ack_o),
    .host_error_o       (host_error_o),
    .host_read_data_o   (host_read_data_o),
    .inport_wr_o        (inport_wr_o),
    .inport_rd_o        (inport_rd_o),
    .inport_addr_o      (inport_addr_o),
    .inport_write_data_o(inport_write_data_o),
    .inport_accept_i    (inport_accept_i),
    .inport_ack_i       (inport_ack_i),
    .inport_error_i     (inport_error_i),
    .inport_read_data_i (inport_read_data_i),
    .level_o            (level_o),
    .protocol_err_o     (protocol_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    host_wr_i          = 4'h0;
    host_rd_i          = 1'b0;
    host_addr_i        = '0;
    host_write_data_i  = '0;
    inport_accept_i    = 1'b0;
    inport_ack_i       = 1'b0;
    inport_error_i     = 1'b0;
    inport_read_data_i = '0;
  endtask

  // Advance to just after the next rising edge; inputs change there, outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
  endtask

  // iflg = {rd, accept, ack, error}; eflg = {host_accept, inport_rd, check_addr, host_ack, host_error}
  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  iflg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  eflg;
    logic [3:0]  e_wr;
    logic [31:0] e_addr;
    logic [2:0]  e_lvl;
    logic [31:0] e_hdata;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] wr, input logic [3:0] iflg, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] eflg,
                              input logic [3:0] e_wr, input logic [31:0] e_addr, input logic [2:0] e_lvl,
                              input logic [31:0] e_hdata);
    vec_t v;
    v.wr = wr; v.iflg = iflg; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.eflg = eflg; v.e_wr = e_wr; v.e_addr = e_addr; v.e_lvl = e_lvl; v.e_hdata = e_hdata;
    return v;
  endfunction

  vec_t       vt[$];
  sdram_req_t mq[$];
  sdram_req_t r;
  int         mout;
  int         n;
  logic       e_hack;
  logic       e_herr;
  logic [31:0] e_hdata;
  logic       req, full, nonempty, inr, issue, local_pop, fire;

  initial begin
    rst_i = 1'b1;
    idle();

    // Read round-trip, out-of-range ordering, combined rd+wr stored as write.
    vt.push_back(mk(4'h0, 4'b1000, 32'h0000_1000, '0, '0,           5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b11100, 4'h0, 32'h0000_1000, 3'd1, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b11100, 4'h0, 32'h0000_1000, 3'd1, '0));
    vt.push_back(mk(4'h0, 4'b0100, '0,            '0, '0,           5'b11100, 4'h0, 32'h0000_1000, 3'd1, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0010, '0,            '0, 32'hDEADBEEF, 5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10010, 4'h0, '0,           3'd0, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10000, 4'h0, '0,           3'd0, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b1000, 32'h0000_0010, '0, '0,           5'b10000, 4'h0, '0,           3'd0, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b1100, 32'h0200_0000, '0, '0,           5'b11100, 4'h0, 32'h0000_0010, 3'd1, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10100, 4'h0, 32'h0200_0000, 3'd1, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b0010, '0,            '0, 32'h0000_1234, 5'b10100, 4'h0, 32'h0200_0000, 3'd1, 32'hDEADBEEF));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10110, 4'h0, 32'h0200_0000, 3'd1, 32'h0000_1234));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10011, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h3, 4'b1000, 32'h0000_0040, 32'h55, '0,       5'b10000, 4'h0, '0,           3'd0, '0));
    vt.push_back(mk(4'h0, 4'b0100, '0,            '0, '0,           5'b10100, 4'h3, 32'h0000_0040, 3'd1, '0));
    vt.push_back(mk(4'h0, 4'b0000, '0,            '0, '0,           5'b10000, 4'h0, '0,           3'd0, '0));

    do_reset();
    #1;
    chk("reset_ack", host_ack_o, 1'b0);
    chk("reset_level", level_o, 3'd0);
    chk("reset_perr", protocol_err_o, 1'b0);
    cyc();
    foreach (vt[i]) begin
      host_wr_i = vt[i].wr;
      {host_rd_i, inport_accept_i, inport_ack_i, inport_error_i} = vt[i].iflg;
      host_addr_i        = vt[i].addr;
      host_write_data_i  = vt[i].wdata;
      inport_read_data_i = vt[i].rdata;
      #1;
      chk($sformatf("tbl%0d_accept", i), host_accept_o, vt[i].eflg[4]);
      chk($sformatf("tbl%0d_inport_rd", i), inport_rd_o, vt[i].eflg[3]);
      chk($sformatf("tbl%0d_inport_wr", i), inport_wr_o, vt[i].e_wr);
      if (vt[i].eflg[2]) chk($sformatf("tbl%0d_inport_addr", i), inport_addr_o, vt[i].e_addr);
      chk($sformatf("tbl%0d_level", i), level_o, vt[i].e_lvl);
      chk($sformatf("tbl%0d_host_ack", i), host_ack_o, vt[i].eflg[1]);
      chk($sformatf("tbl%0d_host_err", i), host_error_o, vt[i].eflg[0]);
      chk($sformatf("tbl%0d_host_data", i), host_read_data_o, vt[i].e_hdata);
      cyc();
    end

    // Five writes with the controller stalled: fifth refused, head held stable.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      host_wr_i         = 4'hF;
      host_addr_i       = 32'h100 + 32'(i * 4);
      host_write_data_i = 32'hA0 + 32'(i);
      #1;
      chk($sformatf("fill%0d_accept", i), host_accept_o, (i < 4));
      chk($sformatf("fill%0d_level", i), level_o, 32'(i));
      if (i > 0) begin
        chk($sformatf("fill%0d_wr_hold", i), inport_wr_o, 4'hF);
        chk($sformatf("fill%0d_addr_hold", i), inport_addr_o, 32'h100);
        chk($sformatf("fill%0d_data_hold", i), inport_write_data_o, 32'hA0);
      end
      cyc();
    end
    idle();
    #1;
    chk("fill_level_final", level_o, 3'd4);
    chk("fill_wr_final", inport_wr_o, 4'hF);
    chk("fill_addr_final", inport_addr_o, 32'h100);

    // Outstanding limit with a controller that accepts every cycle but never acks.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_rd_i   = 1'b1;
      host_addr_i = 32'h200 + 32'(i * 4);
      cyc();
    end
    idle();
    inport_accept_i = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (inport_rd_o) n++;
      cyc();
    end
    chk("maxo_issued", n, 2);
    #1;
    chk("maxo_rd_blocked", inport_rd_o, 1'b0);
    chk("maxo_level", level_o, 3'd2);
    inport_ack_i = 1'b1;
    cyc();
    inport_ack_i = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (inport_rd_o) n++;
      cyc();
    end
    chk("maxo_after_ack_issued", n, 1);
    #1;
    chk("maxo_after_ack_level", level_o, 3'd1);

    // Accept and ack in the same cycle leave the outstanding count unchanged.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      host_rd_i   = 1'b1;
      host_addr_i = 32'h300 + 32'(i * 4);
      cyc();
    end
    idle();
    inport_accept_i = 1'b1;
    #1;
    chk("aa_first_issue", inport_rd_o, 1'b1);
    cyc();
    inport_ack_i = 1'b1;
    #1;
    chk("aa_same_cycle_issue", inport_rd_o, 1'b1);
    chk("aa_same_cycle_addr", inport_addr_o, 32'h304);
    cyc();
    inport_ack_i = 1'b0;
    #1;
    chk("aa_next_issue", inport_rd_o, 1'b1);
    chk("aa_next_addr", inport_addr_o, 32'h308);
    chk("aa_host_ack", host_ack_o, 1'b1);
    cyc();
    idle();
    #1;
    chk("aa_level", level_o, 3'd0);

    // Stray ack: forwarded, sticky protocol error, cleared only by reset.
    do_reset();
    inport_ack_i       = 1'b1;
    inport_read_data_i = 32'h5A5A;
    cyc();
    idle();
    #1;
    chk("stray_perr", protocol_err_o, 1'b1);
    chk("stray_host_ack", host_ack_o, 1'b1);
    chk("stray_host_data", host_read_data_o, 32'h5A5A);
    host_rd_i   = 1'b1;
    host_addr_i = 32'h400;
    cyc();
    idle();
    for (int k = 0; k < 3; k++) cyc();
    #1;
    chk("stray_perr_sticky", protocol_err_o, 1'b1);
    chk("stray_level", level_o, 3'd1);
    chk("stray_can_issue", inport_rd_o, 1'b1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_perr", protocol_err_o, 1'b0);
    chk("rst_host_ack", host_ack_o, 1'b0);
    chk("rst_host_err", host_error_o, 1'b0);
    chk("rst_host_data", host_read_data_o, 32'h0);
    chk("rst_level", level_o, 3'd0);
    chk("rst_inport_rd", inport_rd_o, 1'b0);
    chk("rst_inport_wr", inport_wr_o, 4'h0);
    chk("rst_inport_addr", inport_addr_o, 32'h0);
    chk("rst_inport_data", inport_write_data_o, 32'h0);
    cyc();
    host_rd_i   = 1'b1;
    host_addr_i = 32'h500;
    cyc();
    idle();
    inport_accept_i = 1'b1;
    #1;
    chk("midrst_issue", inport_rd_o, 1'b1);
    cyc();
    idle();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    inport_ack_i = 1'b1;
    cyc();
    idle();
    #1;
    chk("midrst_late_ack_perr", protocol_err_o, 1'b1);

    // Random traffic against an in-order queue model playing both host and controller.
    do_reset();
    mq.delete();
    mout    = 0;
    e_hack  = 1'b0;
    e_herr  = 1'b0;
    e_hdata = '0;
    for (int c = 0; c < 400; c++) begin
      req       = 1'($urandom % 2);
      host_rd_i = 1'b0;
      host_wr_i = 4'h0;
      if (req) begin
        case ($urandom % 3)
          0:       host_rd_i = 1'b1;
          1:       host_wr_i = 4'($urandom_range(15, 1));
          default: begin host_rd_i = 1'b1; host_wr_i = 4'($urandom_range(15, 1)); end
        endcase
      end
      host_addr_i        = (($urandom % 8) == 0) ? ($urandom | 32'h0200_0000) : ($urandom & 32'h01FF_FFFC);
      host_write_data_i  = $urandom;
      inport_accept_i    = 1'($urandom % 2);
      inport_ack_i       = (mout > 0) && (($urandom % 3) == 0);
      inport_error_i     = inport_ack_i && (($urandom % 4) == 0);
      inport_read_data_i = $urandom;
      #1;
      full     = (mq.size() == DEPTH);
      nonempty = (mq.size() != 0);
      inr      = nonempty && (mq[0].addr[31:SDRAM_ADDR_W+1] == '0);
      issue    = nonempty && inr && (mout < MAXO);
      chk("rnd_accept", host_accept_o, !full);
      chk("rnd_level", level_o, 32'(mq.size()));
      chk("rnd_inport_rd", inport_rd_o, issue && mq[0].rd);
      chk("rnd_inport_wr", inport_wr_o, issue ? mq[0].wr : 4'h0);
      if (nonempty) begin
        chk("rnd_inport_addr", inport_addr_o, mq[0].addr);
        chk("rnd_inport_data", inport_write_data_o, mq[0].data);
      end
      chk("rnd_host_ack", host_ack_o, e_hack);
      chk("rnd_host_err", host_error_o, e_herr);
      chk("rnd_host_data", host_read_data_o, e_hdata);
      chk("rnd_perr", protocol_err_o, 1'b0);

      local_pop = nonempty && !inr && (mout == 0);
      fire      = issue && inport_accept_i;
      if (inport_ack_i) begin
        e_hack = 1'b1; e_herr = inport_error_i; e_hdata = inport_read_data_i;
      end else if (local_pop) begin
        e_hack = 1'b1; e_herr = 1'b1; e_hdata = '0;
      end else begin
        e_hack = 1'b0; e_herr = 1'b0;
      end
      if (fire || local_pop) void'(mq.pop_front());
      mout = mout + (fire ? 1 : 0) - (inport_ack_i ? 1 : 0);
      if (req && !full) begin
        r.wr   = host_wr_i;
        r.rd   = host_rd_i && (host_wr_i == 4'h0);
        r.addr = host_addr_i;
        r.data = host_write_data_i;
        mq.push_back(r);
      end
      cyc();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
